// File: rtl/core0_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core0_pkg
// Description : Shared definitions for the core0 8-bit-instruction stack
//               processor: default widths, opcode encodings, loop-stack
//               entry layout and circular-pointer helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package core0_pkg;

    // Default configuration; the loop-stack entry layout is sized from these.
    localparam int C_WORD_MAG_DEF           = 5;
    localparam int C_WORD_WIDTH_DEF         = 1 << C_WORD_MAG_DEF;
    localparam int C_PROGRAM_ADDR_WIDTH_DEF = 5;

    // Lower part of the data stack lives in a fixed 16-entry circular RAM.
    localparam int C_DSTACK_DEPTH = 16;
    localparam int C_DSP_WIDTH    = 4;

    // Opcode encodings
    localparam logic [7:0] C_OP_NOP     = 8'h00;
    localparam logic [7:0] C_OP_ADD     = 8'h01;
    localparam logic [7:0] C_OP_SUB     = 8'h02;
    localparam logic [7:0] C_OP_AND     = 8'h03;
    localparam logic [7:0] C_OP_OR      = 8'h04;
    localparam logic [7:0] C_OP_XOR     = 8'h05;
    localparam logic [7:0] C_OP_DROP    = 8'h06;
    localparam logic [7:0] C_OP_DUP     = 8'h07;
    localparam logic [7:0] C_OP_SWAP    = 8'h08;
    localparam logic [7:0] C_OP_READ    = 8'h09;
    localparam logic [7:0] C_OP_WRITE   = 8'h0A;
    localparam logic [7:0] C_OP_RET     = 8'h0B;
    localparam logic [7:0] C_OP_CALL    = 8'h0C;
    localparam logic [7:0] C_OP_LOOP    = 8'h0D;
    localparam logic [7:0] C_OP_ENDLOOP = 8'h0E;
    // 0x10-0x1F: IMM (push low nibble); 0x80-0xFF: JMP (target in bits 6:0)
    localparam logic [3:0] C_OP_IMM_HI  = 4'h1;

    typedef struct packed {
        logic [C_WORD_WIDTH_DEF-1:0]         count;
        logic [C_PROGRAM_ADDR_WIDTH_DEF-1:0] start;
    } lstack_entry_t;

    // Pointer width for a circular stack of the given depth (at least 1 bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Circular pointer step; depth need not be a power of two.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int wrap_dec(input int ptr, input int depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_core0.sv
`default_nettype none
// ============================================================================
// Module      : stack_core0
// Description : Datapath, stacks and decode of the core0 stack processor.
//               One instruction per cycle, READ takes an extra stall cycle.
// Ports       : clk, reset (sync, active-high)
//               programmem_addr        - next fetch address (combinational)
//               programmem_read_value  - instruction at current pc
//               programmem_write_value - tied to 0
//               programmem_we          - tied to 0
//               mainmem_read_addr      - low bits of top of data stack
//               mainmem_write_addr     - low bits of top of data stack
//               mainmem_read_value     - word returned one edge after request
//               mainmem_write_value    - second data-stack entry
//               mainmem_we             - write strobe for this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module stack_core0
    import core0_pkg::*;
#(
    parameter int  WORD_MAG           = C_WORD_MAG_DEF,
    parameter int  PROGRAM_ADDR_WIDTH = C_PROGRAM_ADDR_WIDTH_DEF,
    parameter int  MAIN_ADDR_WIDTH    = 2,
    parameter int  CSTACK_DEPTH       = 2,
    parameter int  LSTACK_DEPTH       = 3,
    localparam int WORD_WIDTH         = 1 << WORD_MAG
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
    input  logic [7:0]                    programmem_read_value,
    output logic [WORD_WIDTH-1:0]         programmem_write_value,
    output logic                          programmem_we,
    output logic [MAIN_ADDR_WIDTH-1:0]    mainmem_read_addr,
    output logic [MAIN_ADDR_WIDTH-1:0]    mainmem_write_addr,
    input  logic [WORD_WIDTH-1:0]         mainmem_read_value,
    output logic [WORD_WIDTH-1:0]         mainmem_write_value,
    output logic                          mainmem_we
);

    localparam int CSP_W = ptr_width(CSTACK_DEPTH);
    localparam int LSP_W = ptr_width(LSTACK_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PROGRAM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0]         dstack_top, dstack_top_d;
    logic [C_DSP_WIDTH-1:0]        dsp_q, dsp_d;
    logic [CSP_W-1:0]              csp_q, csp_d;
    logic [LSP_W-1:0]              lsp_q, lsp_d;
    logic                          stall_q, stall_d;

    logic [WORD_WIDTH-1:0]         dstack_ram [C_DSTACK_DEPTH];
    logic [PROGRAM_ADDR_WIDTH-1:0] cstack_q   [CSTACK_DEPTH];
    lstack_entry_t                 lstack_q   [LSTACK_DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [7:0]                    w_op;
    logic [PROGRAM_ADDR_WIDTH-1:0] w_pc_inc;
    logic [C_DSP_WIDTH-1:0]        w_dsp_inc, w_dsp_dec, w_dsp_dec2;
    logic [CSP_W-1:0]              w_csp_inc, w_csp_dec;
    logic [LSP_W-1:0]              w_lsp_inc, w_lsp_dec;
    logic [WORD_WIDTH-1:0]         w_nos, w_nos2;
    lstack_entry_t                 w_ls_cur;
    logic [C_WORD_WIDTH_DEF-1:0]   w_ls_cnt_dec;

    logic                          w_ram_we;
    logic [C_DSP_WIDTH-1:0]        w_ram_waddr;
    logic [WORD_WIDTH-1:0]         w_ram_wdata;
    logic                          w_cs_we;
    logic                          w_ls_we;
    logic [LSP_W-1:0]              w_ls_waddr;
    lstack_entry_t                 w_ls_wdata;
    logic                          w_mem_we;

    assign w_op       = programmem_read_value;
    assign w_pc_inc   = pc_q + PROGRAM_ADDR_WIDTH'(1);
    assign w_dsp_inc  = dsp_q + C_DSP_WIDTH'(1);
    assign w_dsp_dec  = dsp_q - C_DSP_WIDTH'(1);
    assign w_dsp_dec2 = dsp_q - C_DSP_WIDTH'(2);
    assign w_csp_inc  = CSP_W'(wrap_inc(int'(csp_q), CSTACK_DEPTH));
    assign w_csp_dec  = CSP_W'(wrap_dec(int'(csp_q), CSTACK_DEPTH));
    assign w_lsp_inc  = LSP_W'(wrap_inc(int'(lsp_q), LSTACK_DEPTH));
    assign w_lsp_dec  = LSP_W'(wrap_dec(int'(lsp_q), LSTACK_DEPTH));

    // dsp points at the slot holding NOS; the RAM is never reset, so an
    // underflow simply returns whatever was left there.
    assign w_nos        = dstack_ram[dsp_q];
    assign w_nos2       = dstack_ram[w_dsp_dec];
    assign w_ls_cur     = lstack_q[lsp_q];
    assign w_ls_cnt_dec = w_ls_cur.count - C_WORD_WIDTH_DEF'(1);

    // ------------------------------------------------------------------
    // Decode / next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d             = pc_q;
        dstack_top_d     = dstack_top;
        dsp_d            = dsp_q;
        csp_d            = csp_q;
        lsp_d            = lsp_q;
        stall_d          = 1'b0;
        w_ram_we         = 1'b0;
        w_ram_waddr      = w_dsp_inc;
        w_ram_wdata      = dstack_top;
        w_cs_we          = 1'b0;
        w_ls_we          = 1'b0;
        w_ls_waddr       = w_lsp_inc;
        w_ls_wdata.count = C_WORD_WIDTH_DEF'(dstack_top);
        w_ls_wdata.start = C_PROGRAM_ADDR_WIDTH_DEF'(w_pc_inc);
        w_mem_we         = 1'b0;

        if (stall_q) begin
            // Second half of READ: the word requested last cycle is here.
            // pc holds, so the byte fetched meanwhile is fetched again.
            dstack_top_d = mainmem_read_value;
        end else begin
            pc_d = w_pc_inc;
            if (w_op[7]) begin
                pc_d = PROGRAM_ADDR_WIDTH'(w_op[6:0]);
            end else if (w_op[7:4] == C_OP_IMM_HI) begin
                w_ram_we     = 1'b1;
                dsp_d        = w_dsp_inc;
                dstack_top_d = WORD_WIDTH'(w_op[3:0]);
            end else begin
                case (w_op)
                    C_OP_ADD: begin
                        dstack_top_d = w_nos + dstack_top;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_SUB: begin
                        dstack_top_d = w_nos - dstack_top;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_AND: begin
                        dstack_top_d = w_nos & dstack_top;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_OR: begin
                        dstack_top_d = w_nos | dstack_top;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_XOR: begin
                        dstack_top_d = w_nos ^ dstack_top;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_DROP: begin
                        dstack_top_d = w_nos;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_DUP: begin
                        w_ram_we = 1'b1;
                        dsp_d    = w_dsp_inc;
                    end
                    C_OP_SWAP: begin
                        w_ram_we     = 1'b1;
                        w_ram_waddr  = dsp_q;
                        dstack_top_d = w_nos;
                    end
                    C_OP_READ: begin
                        stall_d = 1'b1;
                    end
                    C_OP_WRITE: begin
                        w_mem_we     = 1'b1;
                        dstack_top_d = w_nos2;
                        dsp_d        = w_dsp_dec2;
                    end
                    C_OP_RET: begin
                        pc_d  = cstack_q[csp_q];
                        csp_d = w_csp_dec;
                    end
                    C_OP_CALL: begin
                        w_cs_we      = 1'b1;
                        csp_d        = w_csp_inc;
                        pc_d         = PROGRAM_ADDR_WIDTH'(dstack_top);
                        dstack_top_d = w_nos;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_LOOP: begin
                        w_ls_we      = 1'b1;
                        lsp_d        = w_lsp_inc;
                        dstack_top_d = w_nos;
                        dsp_d        = w_dsp_dec;
                    end
                    C_OP_ENDLOOP: begin
                        if (w_ls_cnt_dec != '0) begin
                            // Write the decremented count back in place.
                            w_ls_we          = 1'b1;
                            w_ls_waddr       = lsp_q;
                            w_ls_wdata.count = w_ls_cnt_dec;
                            w_ls_wdata.start = w_ls_cur.start;
                            pc_d             = PROGRAM_ADDR_WIDTH'(w_ls_cur.start);
                        end else begin
                            lsp_d = w_lsp_dec;
                        end
                    end
                    default: begin
                        // NOP and all unassigned encodings
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            dstack_top <= '0;
            dsp_q      <= '0;
            csp_q      <= '0;
            lsp_q      <= '0;
            stall_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            dstack_top <= dstack_top_d;
            dsp_q      <= dsp_d;
            csp_q      <= csp_d;
            lsp_q      <= lsp_d;
            stall_q    <= stall_d;
        end
    end

    // Stack storage: contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (!reset && w_ram_we) begin
            dstack_ram[w_ram_waddr] <= w_ram_wdata;
        end
        if (!reset && w_cs_we) begin
            cstack_q[w_csp_inc] <= w_pc_inc;
        end
        if (!reset && w_ls_we) begin
            lstack_q[w_ls_waddr] <= w_ls_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Fetch address is forced to 0 in reset so instruction 0 is already
    // waiting in the memory output register when reset drops.
    assign programmem_addr        = reset ? '0 : pc_d;
    assign programmem_write_value = '0;
    assign programmem_we          = 1'b0;
    assign mainmem_read_addr      = MAIN_ADDR_WIDTH'(dstack_top);
    assign mainmem_write_addr     = MAIN_ADDR_WIDTH'(dstack_top);
    assign mainmem_write_value    = w_nos;
    assign mainmem_we             = w_mem_we & ~reset;

endmodule
`default_nettype wire

// File: rtl/core0_base_core.sv
`default_nettype none
// ============================================================================
// Module      : core0_base_core
// Description : Top-level wrapper of the core0 stack processor. Passes the
//               program-memory and main-memory ports straight through to the
//               core instance `core0`.
// Ports       : clk, reset (sync, active-high)
//               programmem_* - instruction fetch port (sync-read memory)
//               mainmem_*    - data load/store port (sync-read memory)
// Revision    : 1.0 - initial release
// ============================================================================
module core0_base_core
    import core0_pkg::*;
#(
    parameter int  WORD_MAG            = C_WORD_MAG_DEF,
    parameter int  PROGRAM_ADDR_WIDTH  = C_PROGRAM_ADDR_WIDTH_DEF,
    parameter int  MAIN_ADDR_WIDTH     = 2,
    parameter int  CSTACK_DEPTH        = 2,
    parameter int  LSTACK_DEPTH        = 3,
    parameter int  CONVEYOR_ADDR_WIDTH = 4,
    localparam int WORD_WIDTH          = 1 << WORD_MAG
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
    input  logic [7:0]                    programmem_read_value,
    output logic [WORD_WIDTH-1:0]         programmem_write_value,
    output logic                          programmem_we,
    output logic [MAIN_ADDR_WIDTH-1:0]    mainmem_read_addr,
    output logic [MAIN_ADDR_WIDTH-1:0]    mainmem_write_addr,
    input  logic [WORD_WIDTH-1:0]         mainmem_read_value,
    output logic [WORD_WIDTH-1:0]         mainmem_write_value,
    output logic                          mainmem_we
);

    // The conveyor buffer is reserved for a future revision; the parameter
    // is accepted so integrations can already set it, but builds nothing.
    if (CONVEYOR_ADDR_WIDTH > 0) begin : g_conveyor_reserved
    end

    stack_core0 #(
        .WORD_MAG           (WORD_MAG),
        .PROGRAM_ADDR_WIDTH (PROGRAM_ADDR_WIDTH),
        .MAIN_ADDR_WIDTH    (MAIN_ADDR_WIDTH),
        .CSTACK_DEPTH       (CSTACK_DEPTH),
        .LSTACK_DEPTH       (LSTACK_DEPTH)
    ) core0 (
        .clk                    (clk),
        .reset                  (reset),
        .programmem_addr        (programmem_addr),
        .programmem_read_value  (programmem_read_value),
        .programmem_write_value (programmem_write_value),
        .programmem_we          (programmem_we),
        .mainmem_read_addr      (mainmem_read_addr),
        .mainmem_write_addr     (mainmem_write_addr),
        .mainmem_read_value     (mainmem_read_value),
        .mainmem_write_value    (mainmem_write_value),
        .mainmem_we             (mainmem_we)
    );

endmodule
`default_nettype wire

// File: tb/tb_core0_base_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_core0_base_core
// Description : Self-checking bench for core0_base_core. Models both
//               synchronous-read memories, runs short programs and compares
//               the per-cycle fetch address / write strobe / top of stack
//               against hand-derived expectations queued before each run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core0_base_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  programmem_addr;
    logic [7:0]  programmem_read_value;
    logic [31:0] programmem_write_value;
    logic        programmem_we;
    logic [1:0]  mainmem_read_addr;
    logic [1:0]  mainmem_write_addr;
    logic [31:0] mainmem_read_value;
    logic [31:0] mainmem_write_value;
    logic        mainmem_we;

    always #5 clk = ~clk;

    core0_base_core dut (
        .clk                    (clk),
        .reset                  (reset),
        .programmem_addr        (programmem_addr),
        .programmem_read_value  (programmem_read_value),
        .programmem_write_value (programmem_write_value),
        .programmem_we          (programmem_we),
        .mainmem_read_addr      (mainmem_read_addr),
        .mainmem_write_addr     (mainmem_write_addr),
        .mainmem_read_value     (mainmem_read_value),
        .mainmem_write_value    (mainmem_write_value),
        .mainmem_we             (mainmem_we)
    );

    // Memory models: data appears one edge after the address.
    logic [7:0]  prog_mem [32];
    logic [31:0] main_mem [4];
    logic        pre_we = 1'b0;
    logic [1:0]  pre_addr = 2'd0;
    logic [31:0] pre_data = 32'd0;

    always @(posedge clk) begin
        programmem_read_value <= prog_mem[programmem_addr];
        mainmem_read_value    <= main_mem[mainmem_read_addr];
        if (pre_we)
            main_mem[pre_addr] <= pre_data;
        else if (mainmem_we)
            main_mem[mainmem_write_addr] <= mainmem_write_value;
    end

    typedef struct {
        logic [4:0]  addr;
        logic        we;
        logic        chk_top;
        logic [31:0] top;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] prog_q[$];
    int         seq[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++)
            prog_mem[i] = (i < prog_q.size()) ? prog_q[i] : 8'h00;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pre_addr = 2'(a);
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Queue one expected cycle per entry of seq (fetch addresses); the write
    // strobe is expected only in cycle we_at (1-based, 0 = never).
    task automatic push_seq(input int we_at);
        exp_t e;
        foreach (seq[i]) begin
            e.addr    = 5'(seq[i]);
            e.we      = ((i + 1) == we_at);
            e.chk_top = 1'b0;
            e.top     = 32'd0;
            sb.push_back(e);
        end
    endtask

    // Expected top-of-stack as observed during cycle cyc (1-based).
    task automatic want_top(input int cyc, input logic [31:0] v);
        exp_t e;
        e         = sb[cyc - 1];
        e.chk_top = 1'b1;
        e.top     = v;
        sb[cyc - 1] = e;
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, ".rst_addr"}, 32'(programmem_addr), 32'd0);
        check({name, ".rst_we"}, 32'(mainmem_we), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_trace(input string name);
        exp_t e;
        int   k;
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            k++;
            e = sb.pop_front();
            check($sformatf("%s.c%0d.addr", name, k), 32'(programmem_addr), 32'(e.addr));
            check($sformatf("%s.c%0d.we", name, k), 32'(mainmem_we), 32'(e.we));
            if (e.chk_top)
                check($sformatf("%s.c%0d.top", name, k), dut.core0.dstack_top, e.top);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- write: IMM0 IMM0 WRITE ----------------
        reset = 1'b1;
        prog_q = {8'h10, 8'h10, 8'h0A};
        load_prog();
        preload(0, 32'hDEAD_BEEF);
        seq = {1, 2, 3, 4};
        push_seq(3);
        do_reset("write");
        run_trace("write");
        check("write.mem0", main_mem[0], 32'd0);

        // ---------------- add: IMM0 IMM0 ADD IMM0 WRITE ----------------
        reset = 1'b1;
        prog_q = {8'h10, 8'h10, 8'h01, 8'h10, 8'h0A};
        load_prog();
        preload(0, 32'h5555_5555);
        seq = {1, 2, 3, 4, 5, 6};
        push_seq(5);
        want_top(4, 32'd0);
        do_reset("add");
        run_trace("add");
        check("add.mem0", main_mem[0], 32'd0);

        // ---------------- ALU ops, modulo subtract, store of a sum ----------------
        reset = 1'b1;
        prog_q = {8'h1C, 8'h1A, 8'h03, 8'h1C, 8'h1A, 8'h04, 8'h1C, 8'h1A, 8'h05,
                  8'h13, 8'h15, 8'h02, 8'h1F, 8'h1F, 8'h01, 8'h11, 8'h0A};
        load_prog();
        preload(1, 32'h1234_5678);
        seq = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18};
        push_seq(17);
        want_top(4, 32'h0000_0008);
        want_top(7, 32'h0000_000E);
        want_top(10, 32'h0000_0006);
        want_top(13, 32'hFFFF_FFFE);
        want_top(16, 32'h0000_001E);
        do_reset("alu");
        run_trace("alu");
        check("alu.mem1", main_mem[1], 32'h0000_001E);

        // ---------------- synchronous read with stall ----------------
        reset = 1'b1;
        prog_q = {8'h11, 8'h10, 8'h0A, 8'h10, 8'h09, 8'h00, 8'h15, 8'h09, 8'h00};
        load_prog();
        preload(0, 32'h0000_0000);
        preload(1, 32'h0000_00AB);
        seq = {1, 2, 3, 4, 5, 5, 6, 7, 8, 8, 9};
        push_seq(3);
        want_top(7, 32'd1);
        want_top(11, 32'h0000_00AB);
        do_reset("read");
        run_trace("read");
        check("read.mem0", main_mem[0], 32'd1);

        // ---------------- jump / call / return / jump truncation ----------------
        reset = 1'b1;
        prog_q = {};
        load_prog();
        prog_mem[0]  = 8'h85;
        prog_mem[5]  = 8'h1A;
        prog_mem[6]  = 8'h0C;
        prog_mem[10] = 8'h0B;
        prog_mem[7]  = 8'h9F;
        prog_mem[31] = 8'hE3;
        seq = {5, 6, 10, 7, 31, 3, 4};
        push_seq(0);
        want_top(3, 32'h0000_000A);
        do_reset("jump");
        run_trace("jump");

        // ---------------- nested loops: inner body DUP runs 3x per outer pass ----------------
        reset = 1'b1;
        prog_q = {8'h15, 8'h12, 8'h0D, 8'h13, 8'h0D, 8'h07, 8'h0E, 8'h0E, 8'h00};
        load_prog();
        seq = {1, 2, 3, 4, 5, 6, 5, 6, 5, 6, 7, 3, 4, 5, 6, 5, 6, 5, 6, 7, 8, 9};
        push_seq(0);
        want_top(6, 32'd5);
        want_top(22, 32'd5);
        do_reset("loop");
        run_trace("loop");

        // ---------------- reset during the READ stall cycle ----------------
        reset = 1'b1;
        prog_q = {8'h11, 8'h09, 8'h00};
        load_prog();
        preload(1, 32'h0000_0077);
        seq = {1, 2};
        push_seq(0);
        do_reset("rdrst");
        run_trace("rdrst");
        // now 1 time unit into the stall cycle
        check("rdrst.stall_addr", 32'(programmem_addr), 32'd2);
        reset = 1'b1;
        #1;
        check("rdrst.rst_addr", 32'(programmem_addr), 32'd0);
        check("rdrst.rst_we", 32'(mainmem_we), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rdrst.after_top", dut.core0.dstack_top, 32'd0);
        check("rdrst.after_addr", 32'(programmem_addr), 32'd1);
        check("rdrst.after_we", 32'(mainmem_we), 32'd0);
        @(negedge clk);
        check("rdrst.next_top", dut.core0.dstack_top, 32'd1);
        check("rdrst.next_addr", 32'(programmem_addr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
